// File: rtl/ra_bist_gen.sv
// ra_bist_gen: local BIST and manual-access controller
// for parametrised register-file arrays.
module ra_bist_gen #(
    parameter int AW    = 6,
    parameter int DW    = 72,
    parameter int NRD   = 2,
    parameter int RDLAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ctl,
    input  logic              ctl_valid,
    output logic [31:0]       status,
    output logic [DW-1:0]     cap_dat,
    input  logic [NRD-1:0]    rd_enb_in,
    input  logic [NRD*AW-1:0] rd_adr_in,
    output logic [NRD-1:0]    rd_enb_out,
    output logic [NRD*AW-1:0] rd_adr_out,
    input  logic [NRD*DW-1:0] rd_dat,
    input  logic              wr_enb_in,
    input  logic [AW-1:0]     wr_adr_in,
    input  logic [DW-1:0]     wr_dat_in,
    output logic              wr_enb_out,
    output logic [AW-1:0]     wr_adr_out,
    output logic [DW-1:0]     wr_dat_out
);
    localparam int NB = (DW + 31) / 32;
    localparam int LS = RDLAT - 1;
    localparam logic [AW-1:0] AMAX = '1;
    localparam logic [NB*32-1:0] ALT_W = {NB{32'h5555_5555}};
    localparam logic [DW-1:0] ALT = ALT_W[DW-1:0];

    typedef enum logic [3:0] {
        FUNC, HOLD, MRD, MWD, MWR, M0, M1, M2, M3, DRAIN
    } state_t;

    state_t           state, state_d;
    logic [AW-1:0]    a, a_d;
    logic             sub, sub_d;
    logic             tt;
    logic [AW-1:0]    madr;
    logic [3:0]       mport;
    logic [7:0]       bcnt;
    logic [NB*32-1:0] wbuf;
    logic [7:0]       dcnt;

    // read pipeline: valid, kind (1 = march compare), port, adr, expect
    logic             pv [RDLAT];
    logic             pk [RDLAT];
    logic [3:0]       pp [RDLAT];
    logic [AW-1:0]    pa [RDLAT];
    logic [DW-1:0]    pe [RDLAT];

    logic             done, fail;
    logic [7:0]       fcnt, ffadr;
    logic [3:0]       ffport;

    logic [3:0]       op, mp;
    logic             take, busy, man_pend, drain_end;
    logic             cmd_abort, cmd_rd, cmd_wr, cmd_mt;
    logic             iss_v, iss_k;
    logic [3:0]       iss_p;
    logic [AW-1:0]    iss_a;
    logic [DW-1:0]    iss_e, bg, sel;
    logic             cmp_fail, cap_hit;
    logic             unused_bits;

    assign unused_bits = ^{ctl, wbuf};
    assign op = ctl[31:28];
    assign mp = 4'(32'(a) % NRD);
    assign bg = tt ? ALT : '0;
    assign drain_end = (state == DRAIN) && (dcnt == 8'(LS));

    // command decode; data beats of a manual write are never decoded
    always_comb begin
        man_pend = 1'b0;
        for (int k = 0; k < RDLAT; k++)
            if (pv[k] && !pk[k]) man_pend = 1'b1;
        busy = (state inside {MRD, MWD, MWR, M0, M1, M2, M3, DRAIN})
            || man_pend;
        take      = ctl_valid && (state != MWD);
        cmd_abort = take && (op == 4'h0);
        cmd_rd    = take && !busy && (op == 4'h8);
        cmd_wr    = take && !busy && (op == 4'h9);
        cmd_mt    = take && !busy && (op == 4'hF);
    end

    // next state and march address sequencing
    always_comb begin
        state_d = state;
        a_d     = a;
        sub_d   = sub;
        if (cmd_abort) begin
            state_d = FUNC;
        end else if (cmd_rd) begin
            state_d = MRD;
        end else if (cmd_wr) begin
            state_d = MWD;
        end else if (cmd_mt) begin
            state_d = M0;
            a_d     = '0;
            sub_d   = 1'b0;
        end else begin
            case (state)
                MRD: state_d = HOLD;
                MWD: if (ctl_valid && bcnt == 8'(NB - 1)) state_d = MWR;
                MWR: state_d = HOLD;
                M0: begin
                    if (a == AMAX) begin
                        state_d = M1;
                        a_d     = '0;
                    end else a_d = a + 1'b1;
                end
                M1: begin
                    sub_d = !sub;
                    if (sub) begin
                        if (a == AMAX) begin
                            state_d = M2;
                            a_d     = AMAX;
                        end else a_d = a + 1'b1;
                    end
                end
                M2: begin
                    sub_d = !sub;
                    if (sub) begin
                        if (a == '0) begin
                            state_d = M3;
                            a_d     = '0;
                        end else a_d = a - 1'b1;
                    end
                end
                M3: begin
                    if (a == AMAX) state_d = DRAIN;
                    else a_d = a + 1'b1;
                end
                DRAIN: if (drain_end) state_d = HOLD;
                default: ;
            endcase
        end
    end

    // read issued this cycle (manual or march)
    always_comb begin
        iss_v = 1'b0;
        iss_k = 1'b1;
        iss_p = mp;
        iss_a = a;
        iss_e = bg;
        case (state)
            MRD: begin
                iss_v = 32'(mport) < NRD;
                iss_k = 1'b0;
                iss_p = mport;
                iss_a = madr;
            end
            M1: iss_v = !sub;
            M2: begin
                iss_v = !sub;
                iss_e = ~bg;
            end
            M3: iss_v = 1'b1;
            default: ;
        endcase
    end

    // array-side outputs: pass-through in FUNC, local accesses otherwise
    always_comb begin
        rd_enb_out = '0;
        rd_adr_out = '0;
        wr_enb_out = 1'b0;
        wr_adr_out = '0;
        wr_dat_out = '0;
        if (state == FUNC) begin
            rd_enb_out = rd_enb_in;
            rd_adr_out = rd_adr_in;
            wr_enb_out = wr_enb_in;
            wr_adr_out = wr_adr_in;
            wr_dat_out = wr_dat_in;
        end
        for (int p = 0; p < NRD; p++) begin
            if (iss_v && iss_p == 4'(p)) begin
                rd_enb_out[p]           = 1'b1;
                rd_adr_out[p*AW +: AW]  = iss_a;
            end
        end
        case (state)
            MWR: begin
                wr_enb_out = 1'b1;
                wr_adr_out = madr;
                wr_dat_out = wbuf[DW-1:0];
            end
            M0: begin
                wr_enb_out = 1'b1;
                wr_adr_out = a;
                wr_dat_out = bg;
            end
            M1, M2: begin
                wr_enb_out = sub;
                wr_adr_out = sub ? a : '0;
                wr_dat_out = !sub ? '0 : (state == M1) ? ~bg : bg;
            end
            default: ;
        endcase
    end

    // read data of the port at the pipeline output
    always_comb begin
        sel = '0;
        for (int p = 0; p < NRD; p++)
            if (pp[LS] == 4'(p)) sel = rd_dat[p*DW +: DW];
        cmp_fail = pv[LS] && pk[LS] && (sel != pe[LS]) && !cmd_abort;
        cap_hit  = pv[LS] && !pk[LS] && !cmd_abort;
    end

    // FSM state and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FUNC;
            a     <= '0;
            sub   <= 1'b0;
            tt    <= 1'b0;
            madr  <= '0;
            mport <= '0;
            bcnt  <= '0;
            wbuf  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_d;
            a     <= a_d;
            sub   <= sub_d;
            if (cmd_mt) tt <= ctl[0];
            if (cmd_rd || cmd_wr) begin
                madr  <= ctl[AW-1:0];
                mport <= ctl[11:8];
            end
            if (cmd_wr) begin
                bcnt <= '0;
            end else if (state == MWD && ctl_valid) begin
                bcnt <= bcnt + 1'b1;
                for (int i = 0; i < NB; i++)
                    if (bcnt == 8'(i)) wbuf[i*32 +: 32] <= ctl;
            end
            dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
        end
    end

    // read pipeline matching the array read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RDLAT; k++) begin
                pv[k] <= 1'b0;
                pk[k] <= 1'b0;
                pp[k] <= '0;
                pa[k] <= '0;
                pe[k] <= '0;
            end
        end else begin
            pv[0] <= iss_v && !cmd_abort;
            pk[0] <= iss_k;
            pp[0] <= iss_p;
            pa[0] <= iss_a;
            pe[0] <= iss_e;
            for (int k = 1; k < RDLAT; k++) begin
                pv[k] <= pv[k-1] && !cmd_abort;
                pk[k] <= pk[k-1];
                pp[k] <= pp[k-1];
                pa[k] <= pa[k-1];
                pe[k] <= pe[k-1];
            end
        end
    end

    // sticky result flags, fail count and first-fail record
    always_ff @(posedge clk) begin
        if (reset || cmd_abort || cmd_mt) begin
            done   <= 1'b0;
            fail   <= 1'b0;
            fcnt   <= '0;
            ffadr  <= '0;
            ffport <= '0;
        end else begin
            if (cmd_rd || cmd_wr) done <= 1'b0;
            if (drain_end) done <= 1'b1;
            if (cmp_fail) begin
                fail <= 1'b1;
                if (fcnt != 8'hFF) fcnt <= fcnt + 1'b1;
                if (!fail) begin
                    ffadr  <= 8'(pa[LS]);
                    ffport <= pp[LS];
                end
            end
        end
    end

    // manual read capture
    always_ff @(posedge clk) begin
        if (reset) cap_dat <= '0;
        else if (cap_hit) cap_dat <= sel;
    end

    assign status = {state != FUNC, busy, done, fail,
                     fcnt, ffadr, ffport, 8'h00};

endmodule

// File: tb/tb_ra_bist_gen.sv
// tb_ra_bist_gen: randomized self-checking bench for
// ra_bist_gen with a behavioural array and march model.
module tb_ra_bist_gen;
    localparam int AW    = 6;
    localparam int DW    = 72;
    localparam int NRD   = 2;
    localparam int RDLAT = 1;
    localparam int DEPTH = 1 << AW;
    localparam int RAW   = NRD * AW;
    localparam int MCYC  = 6 * DEPTH + RDLAT;
    localparam logic [DW-1:0] ALT = 72'h55_5555_5555_5555_5555;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       ctl = '0;
    logic              ctl_valid = 1'b0;
    logic [31:0]       status;
    logic [DW-1:0]     cap_dat;
    logic [NRD-1:0]    rd_enb_in = '0;
    logic [RAW-1:0]    rd_adr_in = '0;
    logic [NRD-1:0]    rd_enb_out;
    logic [RAW-1:0]    rd_adr_out;
    logic [NRD*DW-1:0] rd_dat;
    logic              wr_enb_in = 1'b0;
    logic [AW-1:0]     wr_adr_in = '0;
    logic [DW-1:0]     wr_dat_in = '0;
    logic              wr_enb_out;
    logic [AW-1:0]     wr_adr_out;
    logic [DW-1:0]     wr_dat_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ra_bist_gen #(.AW(AW), .DW(DW), .NRD(NRD), .RDLAT(RDLAT)) dut (
        .clk(clk), .reset(reset), .ctl(ctl), .ctl_valid(ctl_valid),
        .status(status), .cap_dat(cap_dat),
        .rd_enb_in(rd_enb_in), .rd_adr_in(rd_adr_in),
        .rd_enb_out(rd_enb_out), .rd_adr_out(rd_adr_out),
        .rd_dat(rd_dat),
        .wr_enb_in(wr_enb_in), .wr_adr_in(wr_adr_in),
        .wr_dat_in(wr_dat_in),
        .wr_enb_out(wr_enb_out), .wr_adr_out(wr_adr_out),
        .wr_dat_out(wr_dat_out)
    );

    // behavioural array, one-cycle read latency, optional stuck-at-1
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdq [NRD];
    logic          fault_en = 1'b0;
    int            fault_adr = 0;

    function automatic logic [DW-1:0] arr_rd(int p, int adr);
        logic [DW-1:0] v;
        v = mem[adr];
        if (fault_en && adr == fault_adr && p == 0) v[7] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (wr_enb_out) mem[wr_adr_out] <= wr_dat_out;
        for (int p = 0; p < NRD; p++)
            if (rd_enb_out[p])
                rdq[p] <= arr_rd(p, int'(rd_adr_out[p*AW +: AW]));
    end

    always_comb begin
        rd_dat = '0;
        for (int p = 0; p < NRD; p++) rd_dat[p*DW +: DW] = rdq[p];
    end

    // access monitor for test-mode traffic
    int            wr_pulses = 0;
    int            rd_pulses = 0;
    int            last_rport = 0;
    logic [AW-1:0] last_wadr, last_radr;
    logic [DW-1:0] last_wdat;
    logic [DW-1:0] last_cap = '0;

    always @(posedge clk) begin
        if (!reset && status[31]) begin
            if (wr_enb_out) begin
                wr_pulses++;
                last_wadr = wr_adr_out;
                last_wdat = wr_dat_out;
            end
            for (int p = 0; p < NRD; p++) begin
                if (rd_enb_out[p]) begin
                    rd_pulses++;
                    last_radr = rd_adr_out[p*AW +: AW];
                    last_rport = p;
                end
            end
        end
    end

    // march reference: plain loops over an ideal array
    function automatic void march_ref(input bit t, input bit fen,
                                      input int fadr, output int cnt,
                                      output int ffa, output int ffp);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] b, v, e;
        int adr, p;
        b = t ? ALT : '0;
        cnt = 0;
        ffa = 0;
        ffp = 0;
        for (int i = 0; i < DEPTH; i++) m[i] = b;
        for (int ph = 1; ph <= 3; ph++) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr = (ph == 2) ? DEPTH - 1 - i : i;
                p = adr % NRD;
                e = (ph == 2) ? ~b : b;
                v = m[adr];
                if (fen && adr == fadr && p == 0) v[7] = 1'b1;
                if (v != e) begin
                    if (cnt == 0) begin
                        ffa = adr;
                        ffp = p;
                    end
                    if (cnt < 255) cnt++;
                end
                if (ph == 1) m[adr] = ~b;
                if (ph == 2) m[adr] = b;
            end
        end
    endfunction

    task automatic put(input logic [31:0] w);
        @(negedge clk);
        ctl = w;
        ctl_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        ctl_valid = 1'b0;
        ctl = '0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (status[30] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (status[30]) begin
            errors++;
            $display("FAIL %s: still busy, status=%h", nm, status);
        end
    endtask

    task automatic check_pass(input string nm);
        #1;
        checks++;
        if (rd_enb_out !== rd_enb_in || rd_adr_out !== rd_adr_in ||
            wr_enb_out !== wr_enb_in || wr_adr_out !== wr_adr_in ||
            wr_dat_out !== wr_dat_in) begin
            errors++;
            $display("FAIL %s: out %b %h %b %h %h want %b %h %b %h %h",
                     nm, rd_enb_out, rd_adr_out, wr_enb_out, wr_adr_out,
                     wr_dat_out, rd_enb_in, rd_adr_in, wr_enb_in,
                     wr_adr_in, wr_dat_in);
        end
    endtask

    task automatic manual_wr(input logic [AW-1:0] adr,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input string nm);
        int w0 = wr_pulses;
        logic [DW-1:0] d = DW'({b2, b1, b0});
        put(32'h9000_0000 | 32'(adr));
        put(b0);
        put(b1);
        put(b2);
        idle();
        wait_idle(nm);
        checks++;
        if (wr_pulses != w0 + 1 || last_wadr !== adr || last_wdat !== d) begin
            errors++;
            $display("FAIL %s: pulses %0d adr %h dat %h want 1 %h %h",
                     nm, wr_pulses - w0, last_wadr, last_wdat, adr, d);
        end
    endtask

    task automatic manual_rd(input int port, input logic [AW-1:0] adr,
                             input logic [DW-1:0] d, input string nm);
        int r0 = rd_pulses;
        put(32'h8000_0000 | (32'(port) << 8) | 32'(adr));
        idle();
        wait_idle(nm);
        checks++;
        if (rd_pulses != r0 + 1 || last_rport != port || last_radr !== adr) begin
            errors++;
            $display("FAIL %s access: n %0d port %0d adr %h want 1 %0d %h",
                     nm, rd_pulses - r0, last_rport, last_radr, port, adr);
        end
        checks++;
        if (cap_dat !== d || status[31:30] !== 2'b10) begin
            errors++;
            $display("FAIL %s cap: cap %h st %b want %h 10",
                     nm, cap_dat, status[31:30], d);
        end
        last_cap = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd_enb_in = 2'b11;
        rd_adr_in = {6'd9, 6'd5};
        wr_enb_in = 1'b1;
        wr_adr_in = 6'd3;
        wr_dat_in = 72'hA5_0123_4567_89AB_CDEF;
        #1;
        checks++;
        if (status !== 32'h0 || cap_dat !== '0) begin
            errors++;
            $display("FAIL reset: status %h cap %h want 0 0", status, cap_dat);
        end
        check_pass("reset_pass");
        @(negedge clk);
        rd_enb_in = '0;
        wr_enb_in = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_enb_in = NRD'($urandom);
            rd_adr_in = RAW'($urandom);
            wr_enb_in = 1'($urandom);
            wr_adr_in = AW'($urandom);
            wr_dat_in = DW'({$urandom(), $urandom(), $urandom()});
            check_pass("pass_rand");
        end
        @(negedge clk);
        rd_enb_in = '0;
        wr_enb_in = 1'b0;
    endtask

    task automatic test_manual();
        logic [DW-1:0] d;
        logic [AW-1:0] adr;
        int port;
        manual_wr(6'h12, 32'h1111_1111, 32'h2222_2222, 32'h0000_00AB,
                  "mwr_plan");
        manual_rd(1, 6'h12, 72'hAB_2222_2222_1111_1111, "mrd_plan");
        for (int i = 0; i < 4; i++) begin
            adr = AW'($urandom);
            d = DW'({$urandom(), $urandom(), $urandom()});
            manual_wr(adr, d[31:0], d[63:32],
                      {24'($urandom), d[71:64]}, "mwr_rand");
            port = $urandom_range(NRD - 1, 0);
            manual_rd(port, adr, d, "mrd_rand");
        end
    endtask

    task automatic test_march(input bit t, input bit fen, input int fadr,
                              input string nm);
        int cyc = 0;
        int ecnt, effa, effp, bad;
        logic [DW-1:0] b;
        b = t ? ALT : '0;
        march_ref(t, fen, fadr, ecnt, effa, effp);
        fault_en = fen;
        fault_adr = fadr;
        @(negedge clk);
        ctl = 32'hF000_0000 | 32'(t);
        ctl_valid = 1'b1;
        @(posedge clk);
        #1;
        ctl_valid = 1'b0;
        ctl = '0;
        while (!status[29] && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checks++;
        if (cyc != MCYC) begin
            errors++;
            $display("FAIL %s cycles: got %0d want %0d", nm, cyc, MCYC);
        end
        checks++;
        if (status[31:28] !== {3'b101, ecnt != 0} ||
            status[27:20] !== 8'(ecnt) ||
            status[19:12] !== 8'(effa) || status[11:0] !== {4'(effp), 8'h0}) begin
            errors++;
            $display("FAIL %s status: got %h want flags %b cnt %0d adr %h port %0d",
                     nm, status, {3'b101, ecnt != 0}, ecnt, effa, effp);
        end
        @(negedge clk);
        checks++;
        if (rd_enb_out !== '0 || wr_enb_out !== 1'b0 || status[30] !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: rd %b wr %b busy %b want 0 0 0",
                     nm, rd_enb_out, wr_enb_out, status[30]);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== b) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s array: %0d words differ from background", nm, bad);
        end
        fault_en = 1'b0;
    endtask

    task automatic test_bad_port();
        int r0 = rd_pulses;
        put(32'h8000_0F05);
        idle();
        wait_idle("bad_port");
        checks++;
        if (rd_pulses != r0 || cap_dat !== last_cap || status[31:29] !== 3'b100) begin
            errors++;
            $display("FAIL bad_port: n %0d cap %h st %b want 0 %h 100",
                     rd_pulses - r0, cap_dat, status[31:29], last_cap);
        end
    endtask

    task automatic test_mwd_data();
        logic [31:0] keep;
        keep = {status[31], 1'b0, 1'b0, status[28:0]};
        manual_wr(6'h07, 32'hF000_0001, 32'hF000_0002, 32'h0000_00CD,
                  "mwd_data");
        checks++;
        if (status !== keep) begin
            errors++;
            $display("FAIL mwd_status: got %h want %h", status, keep);
        end
        manual_rd(0, 6'h07, 72'hCD_F000_0002_F000_0001, "mwd_read");
    endtask

    task automatic test_abort();
        @(negedge clk);
        ctl = 32'hF000_0000 | 32'($urandom_range(1, 0));
        ctl_valid = 1'b1;
        @(negedge clk);
        ctl_valid = 1'b0;
        repeat (99) @(negedge clk);
        ctl = 32'h0000_0000;
        ctl_valid = 1'b1;
        @(posedge clk);
        #1;
        ctl_valid = 1'b0;
        checks++;
        if (status !== 32'h0) begin
            errors++;
            $display("FAIL abort: status %h want 0", status);
        end
        rd_enb_in = NRD'($urandom);
        rd_adr_in = RAW'($urandom);
        wr_enb_in = 1'b0;
        wr_adr_in = AW'($urandom);
        wr_dat_in = DW'({$urandom(), $urandom(), $urandom()});
        check_pass("abort_pass");
        repeat (4) @(negedge clk);
        checks++;
        if (status !== 32'h0) begin
            errors++;
            $display("FAIL abort_late: status %h want 0", status);
        end
        rd_enb_in = '0;
    endtask

    task automatic test_reset_mid();
        put(32'hF000_0001);
        idle();
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (status !== 32'h0 || cap_dat !== '0) begin
            errors++;
            $display("FAIL reset_mid: status %h cap %h want 0 0", status, cap_dat);
        end
        rd_enb_in = NRD'($urandom);
        rd_adr_in = RAW'($urandom);
        check_pass("reset_mid_pass");
        rd_enb_in = '0;
    endtask

    initial begin
        int fa;
        test_reset();
        test_passthrough();
        test_manual();
        test_march(1'b0, 1'b0, 0, "march_clean");
        test_bad_port();
        test_march(1'b1, 1'b1, 6'h2A, "march_fault");
        test_mwd_data();
        fa = $urandom_range(DEPTH - 1, 0);
        test_march(1'($urandom), 1'b1, fa, "march_rand");
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
